// File: rtl/enum_type.sv
// Shared types for the Tetris command scheduler: engine states/commands,
// scheduler FSM states, button bit positions and the button decoder.
package enum_type;

    // Engine state (tstate) and engine command (ctrl) share one encoding
    typedef enum logic [3:0] {
        NONE       = 4'd0,
        INIT       = 4'd1,
        GEN        = 4'd2,
        WAIT       = 4'd3,
        DOWN       = 4'd4,
        LEFT       = 4'd5,
        RIGHT      = 4'd6,
        ROTATE     = 4'd7,
        ROTATE_REV = 4'd8,
        DROP       = 4'd9,
        HOLD       = 4'd10,
        BAR        = 4'd11,
        END        = 4'd12
    } state_type;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_BUSY = 2'd2
    } sched_state_t;

    localparam int unsigned BTN_LEFT       = 0;
    localparam int unsigned BTN_RIGHT      = 1;
    localparam int unsigned BTN_DOWN       = 2;
    localparam int unsigned BTN_ROTATE     = 3;
    localparam int unsigned BTN_ROTATE_REV = 4;
    localparam int unsigned BTN_DROP       = 5;
    localparam int unsigned BTN_HOLD       = 6;

    // User commands issued under pending gravity before gravity wins
    localparam logic [2:0] STARVE_LIMIT = 3'd4;

    // Highest set button bit wins when several are pressed together
    function automatic state_type btn_to_cmd(input logic [6:0] b);
        state_type c;
        c = NONE;
        if (b[BTN_HOLD])            c = HOLD;
        else if (b[BTN_DROP])       c = DROP;
        else if (b[BTN_ROTATE_REV]) c = ROTATE_REV;
        else if (b[BTN_ROTATE])     c = ROTATE;
        else if (b[BTN_DOWN])       c = DOWN;
        else if (b[BTN_RIGHT])      c = RIGHT;
        else if (b[BTN_LEFT])       c = LEFT;
        return c;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; otherwise it is dropped.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW + 1)'(DEPTH));
    assign dout      = r_mem[r_rptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Pointer and occupancy tracking; flush empties the queue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

    // Storage write; contents are don't-care until pointed at
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wptr] <= din;
    end

endmodule

// File: rtl/tetris_cmd_sched.sv
// Arbitrates garbage rows, gravity ticks and user buttons into a single
// one-cycle command stream for the Tetris engine, one command per WAIT.
module tetris_cmd_sched
    import enum_type::*;
#(
    parameter int unsigned GRAVITY_PERIOD = 100_000_000,
    parameter int unsigned QDEPTH         = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [6:0] btn,
    input  logic [2:0] gravity_shift,
    input  logic       bar_req,
    input  logic [9:0] bar_in,
    input  state_type  tstate,
    output state_type  ctrl,
    output logic [9:0] bar_mask,
    output logic       ovf
);

    sched_state_t r_state;
    state_type    r_ctrl;
    logic [9:0]   r_bar_mask;
    logic         r_ovf;
    logic [31:0]  r_grav_cnt;
    logic         r_grav_pend;
    logic [2:0]   r_starve;

    logic        w_active;
    logic        w_start_fire;
    logic        w_can_issue;
    logic        w_user_push;
    logic [3:0]  w_user_din;
    logic [3:0]  w_user_dout;
    logic        w_user_full;
    logic        w_user_empty;
    logic        w_pop_user;
    logic        w_bar_push;
    logic [9:0]  w_bar_dout;
    logic        w_bar_full;
    logic        w_bar_empty;
    logic        w_pop_bar;
    logic        w_user_ovf;
    logic        w_bar_ovf;
    logic        w_issue;
    state_type   w_cmd;
    logic        w_down_issued;
    logic        w_starve_inc;
    logic [31:0] w_period;
    logic        w_grav_tick;

    assign w_active     = (r_state != S_IDLE);
    assign w_start_fire = (r_state == S_IDLE) && start && (tstate == INIT || tstate == END);
    assign w_can_issue  = (r_state == S_ARB) && (tstate == WAIT);

    // Inputs are only queued while a game is running
    assign w_user_push = w_active && (|btn);
    assign w_user_din  = btn_to_cmd(btn);
    assign w_bar_push  = w_active && bar_req;
    assign w_user_ovf  = w_user_push && w_user_full && !w_pop_user;
    assign w_bar_ovf   = w_bar_push && w_bar_full && !w_pop_bar;

    sync_fifo #(
        .WIDTH (4),
        .DEPTH (QDEPTH)
    ) u_user_q (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (w_start_fire),
        .push    (w_user_push),
        .din     (w_user_din),
        .pop     (w_pop_user),
        .dout    (w_user_dout),
        .full    (w_user_full),
        .empty   (w_user_empty)
    );

    sync_fifo #(
        .WIDTH (10),
        .DEPTH (QDEPTH)
    ) u_bar_q (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (w_start_fire),
        .push    (w_bar_push),
        .din     (bar_in),
        .pop     (w_pop_bar),
        .dout    (w_bar_dout),
        .full    (w_bar_full),
        .empty   (w_bar_empty)
    );

    // Period 0 or 1 keeps the counter pinned at 0 and ticks every cycle
    assign w_period    = GRAVITY_PERIOD >> gravity_shift;
    assign w_grav_tick = w_active && ((w_period <= 32'd1) || (r_grav_cnt >= w_period - 32'd1));

    // Pick the next command: garbage, starved gravity, user, then gravity
    always_comb begin
        w_issue    = 1'b0;
        w_cmd      = NONE;
        w_pop_bar  = 1'b0;
        w_pop_user = 1'b0;
        if (w_can_issue) begin
            if (!w_bar_empty) begin
                w_issue   = 1'b1;
                w_cmd     = BAR;
                w_pop_bar = 1'b1;
            end else if (r_grav_pend && (r_starve >= STARVE_LIMIT)) begin
                w_issue = 1'b1;
                w_cmd   = DOWN;
            end else if (!w_user_empty) begin
                w_issue    = 1'b1;
                w_cmd      = state_type'(w_user_dout);
                w_pop_user = 1'b1;
            end else if (r_grav_pend) begin
                w_issue = 1'b1;
                w_cmd   = DOWN;
            end
        end
    end

    // Any DOWN satisfies gravity; non-DOWN user moves under pending gravity starve it
    assign w_down_issued = w_issue && (w_cmd == DOWN);
    assign w_starve_inc  = w_issue && r_grav_pend && (w_cmd != DOWN) && (w_cmd != BAR);

    // Gravity timer, sticky pending flag and starvation count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grav_cnt  <= '0;
            r_grav_pend <= 1'b0;
            r_starve    <= '0;
        end else if (w_start_fire) begin
            r_grav_cnt  <= '0;
            r_grav_pend <= 1'b0;
            r_starve    <= '0;
        end else begin
            if (w_active) r_grav_cnt <= w_grav_tick ? '0 : r_grav_cnt + 32'd1;
            // A fresh tick landing with a DOWN issue starts a new pending period
            if (w_grav_tick)        r_grav_pend <= 1'b1;
            else if (w_down_issued) r_grav_pend <= 1'b0;
            if (w_down_issued) r_starve <= '0;
            else if (w_starve_inc && (r_starve < STARVE_LIMIT)) r_starve <= r_starve + 3'd1;
        end
    end

    // Scheduler FSM with registered ctrl, bar_mask and ovf
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_ctrl     <= NONE;
            r_bar_mask <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_ctrl <= NONE;
            r_ovf  <= w_user_ovf || w_bar_ovf;
            case (r_state)
                S_IDLE: begin
                    if (w_start_fire) begin
                        r_ctrl  <= DOWN;
                        r_state <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (tstate == END || tstate == INIT) begin
                        r_state <= S_IDLE;
                    end else if (w_issue) begin
                        r_ctrl  <= w_cmd;
                        r_state <= S_BUSY;
                        if (w_cmd == BAR) r_bar_mask <= w_bar_dout;
                    end
                end
                S_BUSY: begin
                    if (tstate == END)       r_state <= S_IDLE;
                    else if (tstate != WAIT) r_state <= S_ARB;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ctrl     = r_ctrl;
    assign bar_mask = r_bar_mask;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_tetris_cmd_sched.sv
// Scoreboard bench for tetris_cmd_sched: stimulus pushes expected commands,
// a negedge monitor pops and compares every command the DUT issues.
module tb_tetris_cmd_sched;
    import enum_type::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] btn = '0;
    logic [2:0] gravity_shift = '0;
    logic       bar_req = 1'b0;
    logic [9:0] bar_in = '0;
    state_type  tstate;
    state_type  ctrl;
    logic [9:0] bar_mask;
    logic       ovf;

    // Engine model: tstate comes from the auto responder or from the main sequence
    state_type tst_main = INIT;
    state_type eng_state = WAIT;
    int        eng_busy = 0;
    logic      auto_eng = 1'b0;
    assign tstate = auto_eng ? eng_state : tst_main;

    typedef struct {
        state_type  cmd;
        logic [9:0] mask;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   issue_n = 0;
    int   issue_cyc[64];
    int   ovf_n = 0;

    tetris_cmd_sched #(
        .GRAVITY_PERIOD (16),
        .QDEPTH         (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .btn           (btn),
        .gravity_shift (gravity_shift),
        .bar_req       (bar_req),
        .bar_in        (bar_in),
        .tstate        (tstate),
        .ctrl          (ctrl),
        .bar_mask      (bar_mask),
        .ovf           (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every non-NONE ctrl must match the scoreboard head
    always @(negedge clk) begin
        if (ovf === 1'b1) ovf_n++;
        if (ctrl != NONE) begin
            if (issue_n < 64) issue_cyc[issue_n] = cyc;
            issue_n++;
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_issue: got %s, wanted no command (cycle %0d)",
                         ctrl.name(), cyc);
            end else begin
                mon_e = sb.pop_front();
                if (ctrl !== mon_e.cmd || (mon_e.cmd == BAR && bar_mask !== mon_e.mask)) begin
                    n_fail++;
                    $display("FAIL issue_order: got %s mask %h, wanted %s mask %h (cycle %0d)",
                             ctrl.name(), bar_mask, mon_e.cmd.name(), mon_e.mask, cyc);
                end
            end
        end
    end

    // Engine responder: leaves WAIT for two cycles after each command
    always @(negedge clk) begin
        if (!reset_n) begin
            eng_state = WAIT;
            eng_busy  = 0;
        end else if (ctrl != NONE) begin
            eng_state = ctrl;
            eng_busy  = 2;
        end else if (eng_busy > 0) begin
            eng_busy--;
            if (eng_busy == 0) eng_state = WAIT;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic expect_cmd(input state_type c, input logic [9:0] m);
        exp_t e;
        e.cmd  = c;
        e.mask = m;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, wanted %0h", name, got, want);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic pulse_btn(input logic [6:0] b);
        btn = b;
        tick(1);
        btn = '0;
        tick(1);
    endtask

    task automatic start_game(input state_type from);
        auto_eng = 1'b0;
        tst_main = from;
        expect_cmd(DOWN, 10'h0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic end_game();
        auto_eng = 1'b0;
        tst_main = END;
        tick(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, wanted end of sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int o0;
        int k;
        int base;

        // Reset values
        tick(2);
        check("reset_ctrl", ctrl, NONE);
        check("reset_bar_mask", bar_mask, 10'h0);
        check("reset_ovf", ovf, 1'b0);
        reset_n = 1'b1;
        tick(2);

        // Start from INIT gives one DOWN, then nothing until the first gravity tick
        start_game(INIT);
        tst_main = GEN;
        tick(2);
        auto_eng = 1'b1;
        tick(6);
        check("no_early_gravity", issue_n, 1);
        expect_cmd(DOWN, 10'h0);
        drain("first_gravity_drain", 30);
        check("first_gravity_latency", issue_cyc[1] - issue_cyc[0], 17);

        // Shift 1 halves the period to 8 cycles
        gravity_shift = 3'd1;
        n0 = issue_n;
        repeat (4) expect_cmd(DOWN, 10'h0);
        drain("gravity8_drain", 100);
        check("gravity8_interval_a", issue_cyc[n0 + 2] - issue_cyc[n0 + 1], 8);
        check("gravity8_interval_b", issue_cyc[n0 + 3] - issue_cyc[n0 + 2], 8);
        end_game();
        gravity_shift = 3'd0;

        // Garbage beats a same-cycle LEFT; gravity DOWN trails the user move
        start_game(END);
        auto_eng = 1'b1;
        o0 = ovf_n;
        expect_cmd(BAR, 10'h3FE);
        expect_cmd(LEFT, 10'h0);
        expect_cmd(DOWN, 10'h0);
        bar_in  = 10'h3FE;
        bar_req = 1'b1;
        btn     = 7'b0000001;
        tick(1);
        bar_req = 1'b0;
        btn     = '0;
        drain("bar_left_drain", 60);
        check("bar_mask_held", bar_mask, 10'h3FE);
        check("bar_left_no_ovf", ovf_n - o0, 0);
        end_game();

        // Five RIGHTs into a 4-deep queue: four issue, one overflow pulse
        start_game(END);
        tst_main = DOWN;
        o0 = ovf_n;
        repeat (4) expect_cmd(RIGHT, 10'h0);
        expect_cmd(DOWN, 10'h0);
        repeat (5) pulse_btn(7'b0000010);
        auto_eng = 1'b1;
        drain("right_ovf_drain", 80);
        check("right_ovf_pulses", ovf_n - o0, 1);
        end_game();

        // Pending gravity is forced in after four user commands
        start_game(END);
        tst_main = GEN;
        expect_cmd(LEFT, 10'h0);
        expect_cmd(ROTATE, 10'h0);
        expect_cmd(ROTATE_REV, 10'h0);
        expect_cmd(HOLD, 10'h0);
        expect_cmd(DOWN, 10'h0);
        expect_cmd(DROP, 10'h0);
        expect_cmd(RIGHT, 10'h0);
        expect_cmd(DOWN, 10'h0);
        pulse_btn(7'b0000001);
        pulse_btn(7'b0001011);
        pulse_btn(7'b0010000);
        pulse_btn(7'b1000100);
        tick(12);
        base = issue_n;
        auto_eng = 1'b1;
        k = 0;
        while (issue_n < base + 2 && k < 40) begin
            tick(1);
            k++;
        end
        check("starve_first_two_issued", (issue_n >= base + 2) ? 1 : 0, 1);
        pulse_btn(7'b0100000);
        pulse_btn(7'b0000010);
        drain("starve_drain", 100);
        end_game();

        // Reset while a BAR is on ctrl clears outputs and any queued work
        start_game(END);
        auto_eng = 1'b1;
        bar_in  = 10'h2A5;
        bar_req = 1'b1;
        btn     = 7'b0000001;
        tick(1);
        bar_req = 1'b0;
        btn     = '0;
        k = 0;
        while (k < 30) begin
            @(posedge clk);
            #1;
            if (ctrl == BAR) break;
            k++;
        end
        check("bar_before_reset", ctrl, BAR);
        reset_n = 1'b0;
        #1;
        check("async_reset_ctrl", ctrl, NONE);
        check("async_reset_bar_mask", bar_mask, 10'h0);
        check("async_reset_ovf", ovf, 1'b0);
        tick(2);
        auto_eng = 1'b0;
        tst_main = WAIT;
        reset_n  = 1'b1;
        tick(2);
        btn     = 7'b0000001;
        bar_req = 1'b1;
        tick(1);
        btn     = '0;
        bar_req = 1'b0;
        n0 = issue_n;
        tick(30);
        check("idle_after_reset_no_issue", issue_n, n0);
        start_game(INIT);
        auto_eng = 1'b1;
        expect_cmd(DOWN, 10'h0);
        drain("restart_after_reset_drain", 40);
        end_game();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tetris_cmd_sched.md
TETRIS_CMD_SCHED -- requirements
Module: tetris_cmd_sched

Interface
REQ-001 SHALL have parameter GRAVITY_PERIOD, default 100_000_000: clk cycles between gravity DOWN requests at gravity_shift=0.
REQ-002 SHALL have parameter QDEPTH, default 4: depth of the user-command and garbage queues (power of 2).
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: one-cycle pulse that starts a game from INIT or END.
REQ-006 SHALL have port btn, input, 7: one-cycle pulses {hold, drop, rotate_rev, rotate, down, right, left} (bit6..bit0).
REQ-007 SHALL have port gravity_shift, input, 3: gravity period is GRAVITY_PERIOD >> gravity_shift.
REQ-008 SHALL have port bar_req, input, 1: one-cycle garbage-row request.
REQ-009 SHALL have port bar_in, input, 10: row mask paired with bar_req.
REQ-010 SHALL have port tstate, input, state_type: engine state.
REQ-011 SHALL have port ctrl, output, state_type: registered command to the engine.
REQ-012 SHALL have port bar_mask, output, 10: registered garbage row, valid while ctrl==BAR.
REQ-013 SHALL have port ovf, output, 1: one-cycle pulse when a push hits a full queue.

Function
REQ-014 SHALL implement FSM S_IDLE, S_ARB, S_BUSY.
REQ-015 S_IDLE: on start while tstate is INIT or END, SHALL drive ctrl=DOWN for exactly one cycle, flush both queues, clear the gravity counter, and go to S_ARB.
REQ-016 S_ARB: when tstate==WAIT and a request is pending, SHALL register the winner onto ctrl for exactly one cycle and go to S_BUSY.
REQ-017 S_BUSY: SHALL hold ctrl=NONE, return to S_ARB on the first cycle tstate!=WAIT, and go to S_IDLE on tstate END.
REQ-018 In S_ARB, tstate END or INIT SHALL force S_IDLE.
REQ-019 Priority SHALL be: garbage queue head (BAR) > gravity pending (DOWN) if starved > user queue head > gravity pending.
REQ-020 Gravity SHALL be starved once 4 user commands have issued while gravity_pend=1.
REQ-021 User pushes: several btn bits in one cycle SHALL push only the highest set bit; hold=HOLD, drop=DROP, rotate_rev=ROTATE_REV, rotate=ROTATE, down=DOWN, right=RIGHT, left=LEFT.
REQ-022 A BAR issue SHALL load bar_mask from the garbage-queue head and pop it in the same cycle; bar_mask SHALL hold until the next BAR.
REQ-023 Gravity counter SHALL count only in S_ARB/S_BUSY, set sticky gravity_pend on reaching (GRAVITY_PERIOD>>gravity_shift)-1, reset to 0, and saturate if gravity_shift makes the period 0 or 1.
REQ-024 gravity_pend SHALL clear when DOWN issues from either the gravity or the user source; the starvation count SHALL clear with it.
REQ-025 Pushes to a full queue SHALL be dropped and pulse ovf the next cycle.
REQ-026 A simultaneous push and pop on a full queue SHALL succeed.
REQ-027 btn and bar_req SHALL be ignored in S_IDLE.

Reset
REQ-028 reset_n low SHALL asynchronously force S_IDLE, ctrl=NONE, bar_mask=0, ovf=0, empty queues, gravity counter=0, gravity_pend=0, starvation count=0.
REQ-029 Reset mid-handshake SHALL leave no command pending after release.

Structure
REQ-030 The FSM enum and the btn bit indices SHALL go in package enum_type, next to state_type.
REQ-031 Both queues SHALL instantiate one parameterized sub-module sync_fifo (WIDTH, DEPTH) with push/pop/full/empty.

Verification
REQ-032 Sequence: start in INIT -> ctrl=DOWN for 1 cycle; then tstate GEN->WAIT with no input -> ctrl stays NONE until the gravity tick.
REQ-033 GRAVITY_PERIOD=16, shift=1, tstate held WAIT/toggled -> DOWN issued every 8 cycles.
REQ-034 bar_req(bar_in=10'h3FE) and btn[0] pulsed in the same cycle -> BAR with bar_mask=3FE, then LEFT after tstate re-enters WAIT.
REQ-035 5 btn[1] pulses with QDEPTH=4 while tstate=DOWN -> exactly 4 RIGHT issued, ovf pulsed once.
REQ-036 gravity_pend set, 6 queued user commands -> DOWN issued after the 4th user command.
REQ-037 reset_n low during S_BUSY -> ctrl=NONE immediately; after release, no issue before start.
